carry_bypass_adder_pipe: RTL

CARRY_BYPASS_ADDER_PIPE -- requirements
Module: carry_bypass_adder_pipe

---
 rtl/cba_pkg.sv | 27 ++
 rtl/cba_block.sv | 33 +++
 rtl/carry_bypass_adder_pipe.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/cba_pkg.sv
// Shared definitions for the pipelined carry-bypass adder.
// Holds the parameter defaults, the stage-count derivation and the payload
// carried between pipeline stages. The payload vectors are sized by CBA_WIDTH,
// so the top-level WIDTH must equal CBA_WIDTH.
package cba_pkg;

  localparam int CBA_WIDTH = 32;
  localparam int CBA_BLK   = 4;
  localparam int CBA_BPS   = 2;

  // Number of pipeline stages: each stage covers BPS blocks of BLK bits.
  function automatic int cba_nstg(input int width, input int blk, input int bps);
    return width / (blk * bps);
  endfunction

  // Everything a stage hands to the next one. sum holds the bits resolved so
  // far. a and b keep the effective operands (b already inverted for
  // subtract) so later stages can read their slice.
  typedef struct packed {
    logic                 vld;
    logic                 carry;
    logic [CBA_WIDTH-1:0] sum;
    logic [CBA_WIDTH-1:0] a;
    logic [CBA_WIDTH-1:0] b;
  } cba_stage_t;

endpackage

// File: rtl/cba_block.sv
// One carry-bypass block: a BLK-bit ripple-carry adder whose carry-out is
// taken directly from the block carry-in when every bit propagates. That
// short path lets a carry skip the whole ripple chain.
module cba_block #(
  parameter int BLK = 4
) (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] b,
  input  logic           ci,
  output logic [BLK-1:0] s,
  output logic           co
);

  logic rip_c;
  logic prop;
  logic all_prop;

  // Ripple the carry through the block, then bypass it when all bits propagate.
  always_comb begin
    s        = '0;
    rip_c    = ci;
    prop     = 1'b0;
    all_prop = 1'b1;
    for (int i = 0; i < BLK; i++) begin
      prop     = a[i] ^ b[i];
      s[i]     = prop ^ rip_c;
      rip_c    = (a[i] & b[i]) | (prop & rip_c);
      all_prop = all_prop & prop;
    end
    co = all_prop ? ci : rip_c;
  end

endmodule

// File: rtl/carry_bypass_adder_pipe.sv
// Pipelined carry-bypass adder/subtractor with elastic valid/ready stages.
// {cout,sum} = a + (b ^ {WIDTH{sub}}) + (cin ^ sub). Each of the NSTG stages
// resolves BLK*BPS bits and then registers the carry, the partial sum and the
// operands. Every stage can load when it is empty or when its contents move
// on in the same cycle, so the pipeline sustains one result per clock.
// Optional feature: define CBA_OVERFLOW_EN to add the registered signed
// overflow output ovf.
module carry_bypass_adder_pipe
  import cba_pkg::*;
#(
  parameter int WIDTH = CBA_WIDTH,
  parameter int BLK   = CBA_BLK,
  parameter int BPS   = CBA_BPS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef CBA_OVERFLOW_EN
  output logic             ovf,
`endif
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int SW   = BLK * BPS;
  localparam int NSTG = cba_nstg(WIDTH, BLK, BPS);

  cba_stage_t in_stg;

`ifdef CBA_OVERFLOW_EN
  logic ovf_p;
`endif

  // Stage-0 source: apply the subtract inversion to b and the carry-in.
  always_comb begin
    in_stg       = '0;
    in_stg.vld   = in_valid;
    in_stg.carry = cin ^ sub;
    in_stg.a     = a;
    in_stg.b     = b ^ {WIDTH{sub}};
  end

  for (genvar k = 0; k < NSTG; k++) begin : g_stg
    cba_stage_t      src;
    cba_stage_t      nxt;
    cba_stage_t      stg_p;
    logic            load;
    logic            adv;
    logic [SW-1:0]   s_slice;

    if (k == 0) begin : g_src_in
      assign src = in_stg;
    end else begin : g_src_prev
      assign src = g_stg[k-1].stg_p;
    end

    // A full stage moves on when the next stage (or the output) takes it.
    if (k == NSTG - 1) begin : g_adv_out
      assign adv = stg_p.vld && out_ready;
    end else begin : g_adv_next
      assign adv = stg_p.vld && g_stg[k+1].load;
    end

    assign load = !stg_p.vld || adv;

    for (genvar j = 0; j < BPS; j++) begin : g_blk
      logic           ci;
      logic           co;
      logic [BLK-1:0] s;

      if (j == 0) begin : g_ci_stage
        assign ci = src.carry;
      end else begin : g_ci_chain
        assign ci = g_blk[j-1].co;
      end

      cba_block #(.BLK(BLK)) u_blk (
        .a  (src.a[k*SW + j*BLK +: BLK]),
        .b  (src.b[k*SW + j*BLK +: BLK]),
        .ci (ci),
        .s  (s),
        .co (co)
      );

      assign s_slice[j*BLK +: BLK] = s;
    end

    // Merge this stage's sum bits and carry into the payload.
    always_comb begin
      nxt                   = src;
      nxt.carry             = g_blk[BPS-1].co;
      nxt.sum[k*SW +: SW]   = s_slice;
    end

    // ---- stage k register boundary ----
    // Reset clears the output-visible sum/cout along with the valid flag.
    always_ff @(posedge clk) begin
      if (rst) begin
        stg_p <= '0;
      end else if (load) begin
        stg_p <= nxt;
      end
    end

    if (k == NSTG - 1) begin : g_last
      // The final stage's copy of the operands has no consumer.
      logic unused_ab;
      assign unused_ab = ^{stg_p.a, stg_p.b};

`ifdef CBA_OVERFLOW_EN
      logic ovf_nxt;
      // Overflow: operands of equal sign giving a result of the other sign.
      assign ovf_nxt = (src.a[WIDTH-1] == src.b[WIDTH-1]) &&
                       (s_slice[SW-1] != src.a[WIDTH-1]);

      // Register overflow in step with the final stage.
      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_p <= 1'b0;
        end else if (load) begin
          ovf_p <= ovf_nxt;
        end
      end
`endif
    end
  end

  assign in_ready  = !rst && g_stg[0].load;
  assign out_valid = g_stg[NSTG-1].stg_p.vld;
  assign sum       = g_stg[NSTG-1].stg_p.sum;
  assign cout      = g_stg[NSTG-1].stg_p.carry;

`ifdef CBA_OVERFLOW_EN
  assign ovf = ovf_p;
`endif

endmodule
